aes_round_sched: RTL and testbench

- Sequencing controller for the iterative AES-128 round datapath inside the HWPE engine.
- Accepts a job (block count) from the control FSM and handshakes plaintext blocks in from the streamer. Per block, it issues one load cycle, then N_ROUNDS round-enable cycles with key-expansion steps, and holds the result until the output stream accepts it.
- Pulses done when the last block has been accepted.
- Sits between the HWPE control slave/FSM and the round datapath; it drives the datapath's enables.

---
 rtl/aes_package.sv | 14 +
 rtl/aes_round_counter.sv | 30 +++
 rtl/aes_round_sched.sv | 141 ++++++++++++++
 tb/tb_aes_round_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_package.sv
// Shared types and constants for the AES round engine.
package aes_package;

   localparam int AES_N_ROUNDS_128 = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_IN,
      ST_ROUND,
      ST_OUTPUT,
      ST_DONE
   } aes_sched_state_t;

endpackage

// File: rtl/aes_round_counter.sv
// Loadable up-counter with terminal-count flag; tracks the current AES round.
module aes_round_counter #(
   parameter int W  = 4,
   parameter int TC = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   output logic [W-1:0] value,
   output logic         tc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (inc) begin
         value <= value + 1'b1;
      end
   end

   assign tc = (value == W'(TC));

endmodule

// File: rtl/aes_round_sched.sv
// Sequencing controller for the iterative AES-128 round datapath:
// one load cycle, N_ROUNDS round cycles, then hold the result until accepted.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no job; waits for start_i
// ST_WAIT_IN | waiting for a plaintext block; load on handshake
// ST_ROUND   | one AES round per cycle, key expansion advances
// ST_OUTPUT  | ciphertext valid, held until the output stream accepts
// ST_DONE    | one-cycle done pulse, then back to idle
module aes_round_sched
   import aes_package::*;
#(
   parameter int N_ROUNDS = AES_N_ROUNDS_128,
   parameter int CNT_W    = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] nblocks_i,
   output logic             busy_o,
   output logic             done_o,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             dp_load_o,
   output logic             dp_round_en_o,
   output logic             dp_last_round_o,
   output logic             key_step_o,
   output logic             key_restore_o,
   output logic [3:0]       round_idx_o,
   output logic [CNT_W-1:0] blk_cnt_o
);

   aes_sched_state_t state, state_nxt;
   logic [CNT_W-1:0] nblk;
   logic [CNT_W-1:0] blk_inc;
   logic             last_blk;
   logic             rc_clr, rc_load, rc_inc, rc_tc;

   assign blk_inc  = blk_cnt_o + 1'b1;
   assign last_blk = (blk_inc == nblk);
   assign busy_o   = (state != ST_IDLE);

   aes_round_counter #(
      .W  (4),
      .TC (N_ROUNDS)
   ) u_round_cnt (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .clr      (rc_clr),
      .load     (rc_load),
      .load_val (4'd1),
      .inc      (rc_inc),
      .value    (round_idx_o),
      .tc       (rc_tc)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      in_ready_o      = 1'b0;
      dp_load_o       = 1'b0;
      dp_round_en_o   = 1'b0;
      dp_last_round_o = 1'b0;
      key_step_o      = 1'b0;
      key_restore_o   = 1'b0;
      out_valid_o     = 1'b0;
      done_o          = 1'b0;
      rc_load         = 1'b0;
      rc_inc          = 1'b0;
      rc_clr          = clear_i;
      case (state)
         ST_IDLE: begin
            if (start_i) state_nxt = (nblocks_i != '0) ? ST_WAIT_IN : ST_DONE;
         end
         ST_WAIT_IN: begin
            in_ready_o = 1'b1;
            dp_load_o  = in_valid_i;
            if (in_valid_i) begin
               rc_load   = 1'b1;
               state_nxt = ST_ROUND;
            end
         end
         ST_ROUND: begin
            dp_round_en_o   = 1'b1;
            key_step_o      = 1'b1;
            dp_last_round_o = rc_tc;
            if (rc_tc) begin
               rc_clr    = 1'b1;
               state_nxt = ST_OUTPUT;
            end else begin
               rc_inc = 1'b1;
            end
         end
         ST_OUTPUT: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               if (last_blk) begin
                  state_nxt = ST_DONE;
               end else begin
                  // next block restarts key expansion from the initial key
                  key_restore_o = 1'b1;
                  state_nxt     = ST_WAIT_IN;
               end
            end
         end
         ST_DONE: begin
            done_o    = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (clear_i) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         blk_cnt_o <= '0;
         nblk      <= '0;
      end else if (clear_i) begin
         blk_cnt_o <= '0;
         nblk      <= '0;
      end else if (state == ST_IDLE && start_i) begin
         blk_cnt_o <= '0;
         nblk      <= nblocks_i;
      end else if (state == ST_OUTPUT && out_ready_i) begin
         blk_cnt_o <= blk_inc;
      end
   end

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: two instances (10 and 14 rounds) share stimulus and are
// checked every cycle against a job/block-level model, plus directed literal checks.
module tb_aes_round_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] nblocks = '0;

   logic        busy [2], done [2], in_ready [2], out_valid [2], dp_load [2];
   logic        round_en [2], last_rnd [2], key_step [2], key_restore [2];
   logic [3:0]  ridx [2];
   logic [15:0] blk [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes_round_sched #(.N_ROUNDS(10), .CNT_W(16)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start), .nblocks_i(nblocks),
      .busy_o(busy[0]), .done_o(done[0]), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
      .out_valid_o(out_valid[0]), .out_ready_i(out_ready), .dp_load_o(dp_load[0]),
      .dp_round_en_o(round_en[0]), .dp_last_round_o(last_rnd[0]), .key_step_o(key_step[0]),
      .key_restore_o(key_restore[0]), .round_idx_o(ridx[0]), .blk_cnt_o(blk[0]));

   aes_round_sched #(.N_ROUNDS(14), .CNT_W(16)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start), .nblocks_i(nblocks),
      .busy_o(busy[1]), .done_o(done[1]), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
      .out_valid_o(out_valid[1]), .out_ready_i(out_ready), .dp_load_o(dp_load[1]),
      .dp_round_en_o(round_en[1]), .dp_last_round_o(last_rnd[1]), .key_step_o(key_step[1]),
      .key_restore_o(key_restore[1]), .round_idx_o(ridx[1]), .blk_cnt_o(blk[1]));

   function automatic logic [28:0] obs(int k);
      return {busy[k], done[k], in_ready[k], out_valid[k], dp_load[k], round_en[k],
              last_rnd[k], key_step[k], key_restore[k], ridx[k], blk[k]};
   endfunction

   // model: job in progress, current round (0 = none), result held, done pending, counts
   int  nr [2] = '{10, 14};
   bit  m_job [2], m_hold [2], m_done [2];
   int  m_rnd [2], m_nblk [2], m_blk [2];

   task automatic mreset(int k);
      m_job[k] = 0; m_hold[k] = 0; m_done[k] = 0;
      m_rnd[k] = 0; m_nblk[k] = 0; m_blk[k] = 0;
   endtask

   task automatic model_cmp();
      for (int k = 0; k < 2; k++) begin
         logic [28:0] exp_v, act_v;
         bit ir, fin, acc;
         if (!rst_n) mreset(k);
         ir  = m_job[k] && m_rnd[k] == 0 && !m_hold[k];
         acc = m_hold[k] && out_ready;
         fin = acc && (m_blk[k] + 1 == m_nblk[k]);
         exp_v = {m_job[k] || m_done[k], m_done[k], ir, m_hold[k], ir && in_valid,
                  m_rnd[k] != 0, m_rnd[k] == nr[k], m_rnd[k] != 0, acc && !fin,
                  4'(m_rnd[k]), 16'(m_blk[k])};
         act_v = obs(k);
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cyc_dut%0d t=%0t act=%h exp=%h", k, $time, act_v, exp_v);
         end
         if (rst_n) begin
            if (clear) mreset(k);
            else if (m_done[k]) m_done[k] = 0;
            else if (!m_job[k]) begin
               if (start) begin
                  m_blk[k] = 0;
                  m_nblk[k] = int'(nblocks);
                  if (nblocks == 0) m_done[k] = 1;
                  else m_job[k] = 1;
               end
            end else if (m_rnd[k] != 0) begin
               if (m_rnd[k] == nr[k]) begin
                  m_rnd[k] = 0;
                  m_hold[k] = 1;
               end else m_rnd[k]++;
            end else if (m_hold[k]) begin
               if (out_ready) begin
                  m_blk[k]++;
                  m_hold[k] = 0;
                  if (m_blk[k] == m_nblk[k]) begin
                     m_job[k] = 0;
                     m_done[k] = 1;
                  end
               end
            end else if (in_valid) m_rnd[k] = 1;
         end
      end
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   int cyc;
   int st_loads [2], st_rounds [2], st_restores [2], st_dones [2], st_busy [2];
   int st_tload [2], st_tout [2], st_tdone [2], st_blkdone [2], st_lastcnt [2], st_lastidx [2];
   bit stall_seen, stall_drop, injected;

   task automatic clear_stats();
      cyc = 0;
      for (int k = 0; k < 2; k++) begin
         st_loads[k] = 0; st_rounds[k] = 0; st_restores[k] = 0; st_dones[k] = 0;
         st_busy[k] = 0; st_tload[k] = -1; st_tout[k] = -1; st_tdone[k] = -1;
         st_blkdone[k] = -1; st_lastcnt[k] = 0; st_lastidx[k] = -1;
      end
   endtask

   task automatic collect();
      for (int k = 0; k < 2; k++) begin
         if (dp_load[k]) begin
            st_loads[k]++;
            if (st_tload[k] < 0) st_tload[k] = cyc;
         end
         if (round_en[k]) st_rounds[k]++;
         if (last_rnd[k]) begin
            st_lastcnt[k]++;
            st_lastidx[k] = int'(ridx[k]);
         end
         if (key_restore[k]) st_restores[k]++;
         if (out_valid[k] && st_tout[k] < 0) st_tout[k] = cyc;
         if (done[k]) begin
            st_dones[k]++;
            st_tdone[k] = cyc;
            st_blkdone[k] = int'(blk[k]);
         end
         if (busy[k]) st_busy[k]++;
      end
   endtask

   // called at a falling edge after inputs are set; returns at the next falling edge
   task automatic tick();
      #2 collect();
      #2 model_cmp();
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_job(int nb, int stall_blk, bit iv_gap, bit inj);
      int stall_left = 0;
      clear_stats();
      stall_seen = 0; stall_drop = 0; injected = 0;
      for (int c = 0; c < 600; c++) begin
         start   = (c == 0);
         nblocks = (c == 0) ? 16'(nb) : nblocks;
         in_valid = iv_gap ? (c % 3 != 1) : 1'b1;
         if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
            if (!out_valid[0]) stall_drop = 1;
         end else out_ready = 1'b1;
         if (stall_blk >= 0 && !stall_seen && last_rnd[0] && int'(blk[0]) == stall_blk) begin
            stall_seen = 1;
            stall_left = 5;
         end
         if (inj && !injected && ridx[0] == 4'd3 && blk[0] == 16'd0) begin
            start = 1'b1;
            nblocks = 16'd7;
            injected = 1;
         end
         tick();
         if (st_dones[0] > 0 && st_dones[1] > 0) break;
      end
      start = 1'b0;
      chk("job_finished", int'(st_dones[0] > 0 && st_dones[1] > 0), 1);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) mreset(k);
      #1;
      chk("rst_out0", int'(obs(0)), 0);
      chk("rst_out1", int'(obs(1)), 0);
      @(negedge clk);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // single block, 10 rounds
      run_job(1, -1, 0, 0);
      chk("t1_loads", st_loads[0], 1);
      chk("t1_rounds", st_rounds[0], 10);
      chk("t1_lastcnt", st_lastcnt[0], 1);
      chk("t1_lastidx", st_lastidx[0], 10);
      chk("t1_latency", st_tout[0] - st_tload[0], 11);
      chk("t1_done_after_out", st_tdone[0] - st_tout[0], 1);
      chk("t1_blkcnt", st_blkdone[0], 1);
      chk("t1_restores", st_restores[0], 0);
      chk("t1_latency14", st_tout[1] - st_tload[1], 15);

      // three blocks with a 5-cycle output stall on block 2
      run_job(3, 1, 0, 0);
      chk("t2_stall_seen", int'(stall_seen), 1);
      chk("t2_stall_drop", int'(stall_drop), 0);
      chk("t2_restores", st_restores[0], 2);
      chk("t2_dones", st_dones[0], 1);
      chk("t2_blkcnt", st_blkdone[0], 3);
      chk("t2_loads", st_loads[0], 3);

      // empty job
      run_job(0, -1, 0, 0);
      chk("t3_tdone", st_tdone[0], 1);
      chk("t3_busy_cycles", st_busy[0], 1);
      chk("t3_dp_activity", st_loads[0] + st_rounds[0] + st_restores[0], 0);

      // clear during round 6 of block 1
      clear_stats();
      start = 1'b1; nblocks = 16'd4; in_valid = 1'b1; out_ready = 1'b1;
      begin
         bit hit = 0;
         for (int c = 0; c < 40 && !hit; c++) begin
            if (ridx[0] == 4'd6) begin
               clear = 1'b1;
               hit = 1;
            end
            tick();
            start = 1'b0;
            clear = 1'b0;
         end
         chk("t4_reached_round6", int'(hit), 1);
      end
      chk("t4_busy", int'(busy[0]), 0);
      chk("t4_ridx", int'(ridx[0]), 0);
      chk("t4_blk", int'(blk[0]), 0);
      chk("t4_no_done", st_dones[0] + st_dones[1], 0);
      chk("t4_busy14", int'(busy[1]), 0);
      run_job(2, -1, 0, 0);
      chk("t4_fresh_dones", st_dones[0], 1);
      chk("t4_fresh_blkcnt", st_blkdone[0], 2);

      // start pulse during ROUND is ignored
      run_job(2, -1, 0, 1);
      chk("t5_injected", int'(injected), 1);
      chk("t5_dones", st_dones[0], 1);
      chk("t5_blkcnt", st_blkdone[0], 2);
      chk("t5_loads", st_loads[0], 2);

      // 14-round instance, two blocks, gapped input
      run_job(2, -1, 1, 0);
      chk("sw_latency14", st_tout[1] - st_tload[1], 15);
      chk("sw_lastidx14", st_lastidx[1], 14);
      chk("sw_lastcnt14", st_lastcnt[1], 2);
      chk("sw_rounds14", st_rounds[1], 28);
      chk("sw_blkcnt14", st_blkdone[1], 2);

      // asynchronous reset while holding a result
      clear_stats();
      start = 1'b1; nblocks = 16'd1; in_valid = 1'b1; out_ready = 1'b0;
      for (int c = 0; c < 40 && !out_valid[0]; c++) begin
         tick();
         start = 1'b0;
      end
      chk("t6_in_output", int'(out_valid[0]), 1);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_async_out0", int'(obs(0)), 0);
      chk("t6_async_out1", int'(obs(1)), 0);
      model_cmp();
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
